// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_drv_pkg;

  // Number of flops in each readback synchroniser chain.
  localparam int SYNC_STAGES = 2;

  // Sequencer phases, in the order they are visited.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5
  } state_t;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/response bus between a controller (master) and the latch driver (slave).
//
// Handshake: a request is accepted on a rising clk edge where req_valid and
// req_ready are both high; req_val is captured on that edge. req_ready is high
// only while the driver is idle, and a request seen while busy is dropped, not
// queued. resp_valid is a one-cycle strobe with no backpressure; resp_ok is
// meaningful only in the cycle resp_valid is high.
interface sr_latch_driver_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic resp_valid;
  logic resp_ok;

  modport master (
    output req_valid,
    output req_val,
    input  req_ready,
    input  resp_valid,
    input  resp_ok
  );

  modport slave (
    input  req_valid,
    input  req_val,
    output req_ready,
    output resp_valid,
    output resp_ok
  );
endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchroniser for one asynchronous latch readback bit.
module sync2
  import sr_drv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  // Shift the asynchronous input through the flop chain; clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences setup / enable pulse / hold / settle on a gated SR latch, then
// checks the synchronised readback against the requested value.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus,
  output logic               lat_e,
  output logic               lat_s,
  output logic               lat_r,
  input  logic               lat_q,
  input  logic               lat_qn,
  output logic               busy,
  output state_t             dbg_state_o
);

  // Each phase counter loads N-1 on entry and leaves the phase at zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SYNC_STAGES + SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tgt_q, tgt_d;
  logic               lat_e_q, lat_s_q, lat_r_q;
  logic               resp_valid_q, resp_ok_q, busy_q, req_ready_q;
  logic               drive_d, resp_valid_d, resp_ok_d;
  logic               q_sync, qn_sync;

  sync2 u_sync_q  (.clk(clk), .rst_n(rst_n), .d_i(lat_q),  .q_o(q_sync));
  sync2 u_sync_qn (.clk(clk), .rst_n(rst_n), .d_i(lat_qn), .q_o(qn_sync));

  // Next-state, phase counter and target capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          tgt_d   = bus.req_val;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin state_d = ST_PULSE; cnt_d = PULSE_LD; end
        else cnt_d = cnt_q - 1'b1;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin state_d = ST_HOLD; cnt_d = HOLD_LD; end
        else cnt_d = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin state_d = ST_SETTLE; cnt_d = SETTLE_LD; end
        else cnt_d = cnt_q - 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin state_d = ST_CHECK; cnt_d = '0; end
        else cnt_d = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    drive_d      = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    resp_valid_d = (state_d == ST_CHECK);
    resp_ok_d    = resp_valid_d && (q_sync == tgt_d) && (qn_sync == ~tgt_d);
  end

  // State, counter and registered outputs; reset abandons any sequence with e=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tgt_q        <= 1'b0;
      lat_e_q      <= 1'b0;
      lat_s_q      <= 1'b0;
      lat_r_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      lat_e_q      <= (state_d == ST_PULSE);
      lat_s_q      <= drive_d && tgt_d;
      lat_r_q      <= drive_d && !tgt_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      busy_q       <= (state_d != ST_IDLE);
      req_ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign lat_e          = lat_e_q;
  assign lat_s          = lat_s_q;
  assign lat_r          = lat_r_q;
  assign busy           = busy_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ok    = resp_ok_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: default instance plus a re-parameterised one,
// each with a behavioural gated SR latch on its pins.
module tb_sr_latch_driver;
  import sr_drv_pkg::*;

  localparam int W = 33;  // {resp_ok, due cycle}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and latch models ----------------
  sr_latch_driver_if bus0 ();
  sr_latch_driver_if bus1 ();

  logic [1:0] drv_valid = 2'b00;
  logic [1:0] drv_val   = 2'b00;
  assign bus0.req_valid = drv_valid[0];
  assign bus0.req_val   = drv_val[0];
  assign bus1.req_valid = drv_valid[1];
  assign bus1.req_val   = drv_val[1];

  logic e0, s0, r0, q0, qn0, busy0;
  logic e1, s1, r1, q1, qn1, busy1;
  state_t dbg0, dbg1;

  logic lq0 = 1'b0;
  logic lq1 = 1'b0;
  logic stuck = 1'b0;

  always @(e0 or s0 or r0) if (e0) begin
    if (s0) lq0 = 1'b1;
    else if (r0) lq0 = 1'b0;
  end
  always @(e1 or s1 or r1) if (e1) begin
    if (s1) lq1 = 1'b1;
    else if (r1) lq1 = 1'b0;
  end

  assign q0  = stuck ? 1'b0 : lq0;
  assign qn0 = stuck ? 1'b1 : ~lq0;
  assign q1  = lq1;
  assign qn1 = ~lq1;

  sr_latch_driver dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .lat_e(e0), .lat_s(s0), .lat_r(r0), .lat_q(q0), .lat_qn(qn0),
    .busy(busy0), .dbg_state_o(dbg0)
  );

  sr_latch_driver #(
    .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .SETTLE_CYC(0), .CNT_W(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .lat_e(e1), .lat_s(s1), .lat_r(r1), .lat_q(q1), .lat_qn(qn1),
    .busy(busy1), .dbg_state_o(dbg1)
  );

  wire [1:0] obs_e   = {e1, e0};
  wire [1:0] obs_s   = {s1, s0};
  wire [1:0] obs_r   = {r1, r0};
  wire [1:0] obs_bsy = {busy1, busy0};
  wire [1:0] obs_rdy = {bus1.req_ready, bus0.req_ready};

  // Hand-entered phase lengths of each instance.
  int s_c[2]  = '{1, 3};
  int p_c[2]  = '{2, 1};
  int h_c[2]  = '{1, 2};
  int st_c[2] = '{2, 0};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int resp_cnt0 = 0;
  int resp_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever a response strobe is seen.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus0.resp_valid === 1'b1) begin
      resp_cnt0++;
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp0_unexpected: got resp_ok=%0b expected no response (cycle %0d)", bus0.resp_ok, cyc);
      end else begin
        e = exp_q0.pop_front();
        check("resp0_ok", 32'(bus0.resp_ok), 32'(e[32]));
        check("resp0_cycle", cyc, e[31:0]);
      end
    end
    if (bus1.resp_valid === 1'b1) begin
      resp_cnt1++;
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp1_unexpected: got resp_ok=%0b expected no response (cycle %0d)", bus1.resp_ok, cyc);
      end else begin
        e = exp_q1.pop_front();
        check("resp1_ok", 32'(bus1.resp_ok), 32'(e[32]));
        check("resp1_cycle", cyc, e[31:0]);
      end
    end
  end

  // s and r must never be driven together on either instance.
  always @(negedge clk) begin
    if ((s0 && r0) || (s1 && r1)) begin
      checks++; errors++;
      $display("FAIL sr_exclusive: got s0r0=%0b%0b s1r1=%0b%0b expected never both 1", s0, r0, s1, r1);
    end
  end

  // ---------------- driver ----------------
  // Issue one request, push its expected response, then check pins per cycle.
  task automatic do_req(input int sel, input logic val, input logic ok_exp);
    int s_end, e_lo, e_hi, lat;
    logic [W-1:0] ent;
    s_end = s_c[sel] + p_c[sel] + h_c[sel];
    e_lo  = s_c[sel] + 1;
    e_hi  = s_c[sel] + p_c[sel];
    lat   = s_end + 2 + st_c[sel] + 1;
    @(negedge clk);
    drv_valid[sel] = 1'b1;
    drv_val[sel]   = val;
    @(posedge clk);
    @(negedge clk);
    drv_valid[sel] = 1'b0;
    // Now in cycle 1 after the accept edge; the response lands in cycle lat.
    ent = {ok_exp, 32'(cyc + lat - 1)};
    if (sel == 0) exp_q0.push_back(ent);
    else          exp_q1.push_back(ent);
    for (int k = 1; k <= lat; k++) begin
      check($sformatf("lat_s[%0d]_c%0d", sel, k), 32'(obs_s[sel]), 32'((k <= s_end) && val));
      check($sformatf("lat_r[%0d]_c%0d", sel, k), 32'(obs_r[sel]), 32'((k <= s_end) && !val));
      check($sformatf("lat_e[%0d]_c%0d", sel, k), 32'(obs_e[sel]), 32'((k >= e_lo) && (k <= e_hi)));
      check($sformatf("busy[%0d]_c%0d", sel, k), 32'(obs_bsy[sel]), 32'd1);
      @(negedge clk);
    end
    check($sformatf("ready_after[%0d]", sel), 32'(obs_rdy[sel]), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int saved;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_pins", 32'({e0, s0, r0}), 32'd0);
    check("rst_resp", 32'({bus0.resp_valid, bus0.resp_ok}), 32'd0);
    check("rst_state", 32'(dbg0), 32'(ST_IDLE));

    // Set, then reset, with a working latch
    do_req(0, 1'b1, 1'b1);
    check("latch_q_after_set", 32'(lq0), 32'd1);
    do_req(0, 1'b0, 1'b1);
    check("latch_q_after_reset", 32'(lq0), 32'd0);

    // Stuck readback (q=0, qn=1) while asking for 1
    stuck = 1'b1;
    do_req(0, 1'b1, 1'b0);
    stuck = 1'b0;

    // Busy rejection: req_valid held high, req_val toggling every cycle.
    // Accepts fall on steps 0, 10, 20, where req_val is 1.
    for (int i = 0; i < 30; i++) begin
      int p;
      p = i % 10;
      drv_valid[0] = 1'b1;
      drv_val[0]   = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      if (p == 0) exp_q0.push_back({1'b1, 32'(cyc + 8)});
      if (p < 9) begin
        check($sformatf("rej_ready_s%0d", i), 32'(bus0.req_ready), 32'd0);
        check($sformatf("rej_busy_s%0d", i), 32'(busy0), 32'd1);
        check($sformatf("rej_s_s%0d", i), 32'(s0), 32'(p <= 3));
        check($sformatf("rej_r_s%0d", i), 32'(r0), 32'd0);
      end else begin
        check($sformatf("rej_ready_s%0d", i), 32'(bus0.req_ready), 32'd1);
        check($sformatf("rej_busy_s%0d", i), 32'(busy0), 32'd0);
      end
    end
    drv_valid[0] = 1'b0;
    @(negedge clk);

    // Reset during PULSE: no response, pins released, idle again
    drv_valid[0] = 1'b1;
    drv_val[0]   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    @(negedge clk);
    check("midrst_in_pulse", 32'(e0), 32'd1);
    saved = resp_cnt0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_pins", 32'({e0, s0, r0}), 32'd0);
    check("midrst_ready", 32'(bus0.req_ready), 32'd1);
    check("midrst_busy", 32'(busy0), 32'd0);
    repeat (15) @(negedge clk);
    check("midrst_no_resp", resp_cnt0, saved);

    // Re-parameterised instance: 3+1+2+2+0+1 = 9 cycles
    do_req(1, 1'b1, 1'b1);
    check("sweep_q_after_set", 32'(lq1), 32'd1);
    do_req(1, 1'b0, 1'b1);
    check("sweep_q_after_reset", 32'(lq1), 32'd0);

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 50 && (exp_q0.size() + exp_q1.size()) > 0; i++) @(negedge clk);
    check("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous initiator that drives the enable/set/reset pins of a gated SR latch (e, s, r) and reads back its q/qnot.
- Accepts one write request (target value 0/1) over a valid/ready handshake and sequences setup, enable pulse, hold and settle phases with programmable cycle counts.
- Synchronises the latch outputs, checks them against the target, and returns a one-cycle response with a pass/fail flag.
- Sits between synchronous control logic and any latch-style storage cell.

Parameters:
- SETUP_CYC, 1: cycles s/r are driven with e=0 before the enable pulse (min 1).
- PULSE_CYC, 2: cycles e=1 (min 1).
- HOLD_CYC, 1: cycles s/r stay driven after e falls (min 1).
- SETTLE_CYC, 2: extra cycles after the 2-flop synchroniser delay before sampling (min 0).
- CNT_W, 8: phase counter width; every *_CYC must be < 2^CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  write request present.
- req_val  input  1  target latch value (1=set, 0=reset); sampled on accept.
- req_ready  output  1  high only in IDLE.
- lat_e  output  1  latch enable.
- lat_s  output  1  latch set.
- lat_r  output  1  latch reset.
- lat_q  input  1  latch q, asynchronous.
- lat_qn  input  1  latch qnot, asynchronous.
- resp_valid  output  1  one-cycle response strobe.
- resp_ok  output  1  readback matched; valid only with resp_valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; counter and synchroniser flops clear to 0.
  - lat_e=lat_s=lat_r=0, resp_valid=0, resp_ok=0, busy=0, req_ready=1 (IDLE).
  - A reset mid-sequence abandons the sequence with no response. The latch keeps whatever it holds because e=0.
- All outputs are registered.
- Invariant: lat_s and lat_r are never 1 in the same cycle. lat_e=1 only in PULSE.
- Handshake:
  - Accept occurs when req_valid && req_ready at a clk edge; req_val is captured into tgt.
  - req_valid while busy is ignored, not queued.
- FSM; each phase counter loads N-1 on entry and exits at 0:
  - IDLE: outputs 0. On accept → SETUP.
  - SETUP (SETUP_CYC cycles): lat_s=tgt, lat_r=~tgt, lat_e=0.
  - PULSE (PULSE_CYC cycles): s/r as in SETUP, lat_e=1.
  - HOLD (HOLD_CYC cycles): s/r as in SETUP, lat_e=0.
  - SETTLE (2+SETTLE_CYC cycles): lat_e=lat_s=lat_r=0.
  - CHECK (1 cycle): resp_valid=1; resp_ok=1 only if (q_sync==tgt) && (qn_sync==~tgt). Then → IDLE.
- Latency: resp_valid is high in cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+2+SETTLE_CYC+1 after the accept edge (9 with defaults).
- The earliest next accept is the edge after CHECK, so there is no back-to-back overlap.
- A request whose target equals the current latch value still runs the full sequence.
- q_sync/qn_sync come from independent 2-flop synchronisers. Illegal readback (q==qn) gives resp_ok=0.

Decomposition:
- Package sr_drv_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK);
  - the SYNC_STAGES=2 constant.
- One natural sub-module, sync2: a 2-flop synchroniser with synchronous active-low reset, instantiated twice (q and qnot).
- Counter and FSM live in the top module.

Test Plan:
- Set, defaults, with a behavioural gated-SR latch model attached:
  - Stimulus: pulse req_valid=1, req_val=1.
  - Expected: lat_s=1 for cycles 1–4 after accept, lat_e=1 only in cycles 2–3, resp_valid in cycle 9 with resp_ok=1; q=1 afterwards.
- Reset after set:
  - Stimulus: req_val=0 following the previous test.
  - Expected: lat_r=1 in cycles 1–4, lat_s=0 throughout, resp_ok=1, q=0.
- Stuck latch:
  - Stimulus: force lat_q=0, lat_qn=1 and request req_val=1.
  - Expected: resp_valid in cycle 9 with resp_ok=0.
- Busy rejection:
  - Stimulus: hold req_valid=1 continuously with req_val toggling each cycle.
  - Expected: exactly one accept per 10-cycle sequence; req_ready=0 and busy=1 between accepts; values seen mid-sequence are ignored.
- Reset mid-operation:
  - Stimulus: drive rst_n=0 for one edge during PULSE.
  - Expected: next cycle lat_e=lat_s=lat_r=0, resp_valid never asserts, req_ready=1.
- Parameter sweep:
  - Stimulus: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, SETTLE_CYC=0.
  - Expected: resp_valid in cycle 9 (3+1+2+2+0+1).
  - Assertion on every cycle: lat_s && lat_r never true.
